// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcodes, width codes, writeback
// select codes, FSM encoding, error codes and the latched access record.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // func3 width/sign codes; bits [1:0] give the size, bit 2 means unsigned
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Everything needed to drive the bus and finish the instruction once the
  // EX stage has moved on.
  typedef struct packed {
    logic [31:0] addr;     // word aligned
    logic [1:0]  addr_lo;  // byte offset, needed for load extraction
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic        wr_en;
  } acc_req_t;

endpackage

// File: rtl/mem_stage_load_store_align.sv
// load_store_align: purely combinational byte-lane steering.
//   addr_lo  - byte offset within the word
//   func3    - width/sign code
//   st_data  - store source (rs2)
//   rdata    - raw load word from memory
//   wstrb    - byte strobes for a store of this width/offset
//   wdata    - store data replicated across lanes
//   ld_data  - extracted, extended load value
//   misaligned - half on odd address or word on non-multiple-of-4
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wstrb      = 4'b0000;
    wdata      = '0;
    ld_data    = '0;
    misaligned = 1'b0;
    unique case (func3[1:0])
      2'b00: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = func3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        misaligned = addr_lo[0];
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{st_data[15:0]}};
        ld_data    = func3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      2'b10: begin
        misaligned = |addr_lo;
        wstrb      = 4'b1111;
        wdata      = st_data;
        ld_data    = rdata;
      end
      default: ;  // 011 is not a legal width; treat as a no-op access
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage between EX and WB. Non-memory ops and misaligned
// accesses retire one cycle after acceptance; aligned loads/stores hold EX
// (o_stall) while a single data-memory request is outstanding, which ends on
// ack or after TIMEOUT_CYCLES cycles without one (bus error).
//   clk/rst        - clock, synchronous active-high reset
//   i_*            - instruction from EX (valid, result/address, store data,
//                    pc, func3, opcode, rd, wr_en, resultsrc)
//   o_stall        - EX must hold this cycle
//   o_dmem_*/i_dmem_* - data-memory request/ack interface
//   o_valid, o_wb_data, o_rd, o_wr_en, o_err - retirement to WB
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_result,
  input  logic [31:0] i_data_store,
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_func3,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic        i_wr_en,
  input  logic [1:0]  i_resultsrc,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd,
  output logic        o_wr_en,
  output logic [1:0]  o_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  acc_req_t   acc_q;

  logic        accept, is_load, is_store, is_mem, timeout;
  logic [1:0]  lsa_addr_lo;
  logic [2:0]  lsa_func3;
  logic [3:0]  lsa_wstrb;
  logic [31:0] lsa_wdata, lsa_ld_data;
  logic        lsa_misaligned;

  assign o_stall  = (state == ST_ACCESS);
  assign accept   = i_valid && !o_stall;
  assign is_load  = (i_opcode == OP_LOAD);
  assign is_store = (i_opcode == OP_STORE);
  assign is_mem   = is_load || is_store;
  // The last waiting cycle without ack ends the access.
  assign timeout  = (state == ST_ACCESS) && !i_dmem_ack && (wait_cnt == TO_LAST);

  // Acceptance only happens in IDLE and load extraction only in ACCESS, so a
  // single aligner serves both by switching its select inputs on state.
  assign lsa_addr_lo = o_stall ? acc_q.addr_lo : i_result[1:0];
  assign lsa_func3   = o_stall ? acc_q.func3   : i_func3;

  load_store_align u_align (
    .addr_lo    (lsa_addr_lo),
    .func3      (lsa_func3),
    .st_data    (i_data_store),
    .rdata      (i_dmem_rdata),
    .wstrb      (lsa_wstrb),
    .wdata      (lsa_wdata),
    .ld_data    (lsa_ld_data),
    .misaligned (lsa_misaligned)
  );

  assign o_dmem_req   = o_stall;
  assign o_dmem_we    = o_stall & acc_q.we;
  assign o_dmem_addr  = o_stall ? acc_q.addr  : '0;
  assign o_dmem_wdata = o_stall ? acc_q.wdata : '0;
  assign o_dmem_wstrb = o_stall ? acc_q.wstrb : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept && is_mem && !lsa_misaligned) state_nxt = ST_ACCESS;
      ST_ACCESS: if (i_dmem_ack || timeout)               state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      acc_q     <= '0;
      o_valid   <= 1'b0;
      o_wb_data <= '0;
      o_rd      <= '0;
      o_wr_en   <= 1'b0;
      o_err     <= ERR_NONE;
    end else begin
      o_valid <= 1'b0;
      o_wr_en <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          o_valid <= 1'b1;
          o_rd    <= i_rd;
          o_wr_en <= i_wr_en;
          o_err   <= ERR_NONE;
          unique case (i_resultsrc)
            RS_PC4:  o_wb_data <= i_pc + 32'd4;
            default: o_wb_data <= i_result;
          endcase
        end else if (lsa_misaligned) begin
          o_valid   <= 1'b1;
          o_rd      <= i_rd;
          o_wb_data <= '0;
          o_err     <= ERR_MISALIGN;
        end else begin
          wait_cnt      <= '0;
          acc_q.addr    <= {i_result[31:2], 2'b00};
          acc_q.addr_lo <= i_result[1:0];
          acc_q.wdata   <= is_store ? lsa_wdata : '0;
          acc_q.wstrb   <= is_store ? lsa_wstrb : 4'b0000;
          acc_q.we      <= is_store;
          acc_q.func3   <= i_func3;
          acc_q.rd      <= i_rd;
          acc_q.wr_en   <= i_wr_en && is_load;
        end
      end else if (state == ST_ACCESS) begin
        if (i_dmem_ack) begin
          o_valid   <= 1'b1;
          o_rd      <= acc_q.rd;
          o_wr_en   <= acc_q.wr_en;
          o_err     <= ERR_NONE;
          o_wb_data <= acc_q.we ? '0 : lsa_ld_data;
        end else if (timeout) begin
          o_valid   <= 1'b1;
          o_rd      <= acc_q.rd;
          o_wb_data <= '0;
          o_err     <= ERR_TIMEOUT;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_result, i_data_store, i_pc;
  logic [2:0]  i_func3;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd;
  logic        i_wr_en;
  logic [1:0]  i_resultsrc;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_rd;
  logic        o_wr_en;
  logic [1:0]  o_err;

  int checks = 0;
  int errors = 0;
  int n;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_result(i_result),
    .i_data_store(i_data_store), .i_pc(i_pc), .i_func3(i_func3),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_wr_en(i_wr_en),
    .i_resultsrc(i_resultsrc), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd(o_rd),
    .o_wr_en(o_wr_en), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                       input logic [31:0] sd, input logic [4:0] rd, input logic we,
                       input logic [1:0] rs);
    i_valid = 1'b1; i_opcode = op; i_func3 = f3; i_result = res;
    i_data_store = sd; i_rd = rd; i_wr_en = we; i_resultsrc = rs;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_result = '0; i_data_store = '0; i_pc = '0;
    i_func3 = '0; i_opcode = '0; i_rd = '0; i_wr_en = 1'b0; i_resultsrc = '0;
    i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    rst = 1'b0;
    tick();

    // ADD, ALU writeback
    drive(7'b0110011, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b00);
    chk("add_stall_pre", 32'(o_stall), 32'd0);
    tick(); i_valid = 1'b0;
    chk("add_valid", 32'(o_valid), 32'd1);
    chk("add_wb", o_wb_data, 32'h1234);
    chk("add_rd", 32'(o_rd), 32'd5);
    chk("add_wren", 32'(o_wr_en), 32'd1);
    chk("add_err", 32'(o_err), 32'd0);
    chk("add_stall", 32'(o_stall), 32'd0);
    tick();
    chk("add_valid_pulse", 32'(o_valid), 32'd0);

    // PC+4 wraps modulo 2^32
    drive(7'b1101111, 3'b000, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10);
    i_pc = 32'hFFFF_FFFE;
    tick(); i_valid = 1'b0;
    chk("pc4_wb", o_wb_data, 32'h0000_0002);

    // LB 0x103, ack in 4th request cycle
    drive(7'b0000011, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 2'b01);
    tick(); i_valid = 1'b0;
    n = 0;
    if (o_stall) n++;
    chk("lb_addr", o_dmem_addr, 32'h100);
    chk("lb_req", 32'(o_dmem_req), 32'd1);
    chk("lb_wstrb", 32'(o_dmem_wstrb), 32'd0);
    tick(); if (o_stall) n++;
    tick(); if (o_stall) n++;
    tick(); if (o_stall) n++;
    chk("lb_wait_valid", 32'(o_valid), 32'd0);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h80FF_FF00;
    tick(); i_dmem_ack = 1'b0;
    chk("lb_stall_cycles", 32'(n), 32'd4);
    chk("lb_valid", 32'(o_valid), 32'd1);
    chk("lb_wb", o_wb_data, 32'hFFFF_FF80);
    chk("lb_rd", 32'(o_rd), 32'd7);
    chk("lb_wren", 32'(o_wr_en), 32'd1);
    chk("lb_req_drop", 32'(o_dmem_req), 32'd0);

    // LHU 0x202 with ack already high at acceptance (ignored in IDLE)
    drive(7'b0000011, 3'b101, 32'h202, 32'h0, 5'd3, 1'b1, 2'b01);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h80FF_1234;
    tick(); i_valid = 1'b0;
    chk("lhu_idle_ack_ignored", 32'(o_valid), 32'd0);
    chk("lhu_req", 32'(o_dmem_req), 32'd1);
    tick(); i_dmem_ack = 1'b0;
    chk("lhu_valid", 32'(o_valid), 32'd1);
    chk("lhu_wb", o_wb_data, 32'h0000_80FF);

    // SH 0x202, immediate ack
    drive(7'b0100011, 3'b001, 32'h202, 32'hABCD_1234, 5'd0, 1'b0, 2'b00);
    tick(); i_valid = 1'b0;
    chk("sh_wstrb", 32'(o_dmem_wstrb), 32'hC);
    chk("sh_wdata", o_dmem_wdata, 32'h1234_1234);
    chk("sh_we", 32'(o_dmem_we), 32'd1);
    chk("sh_addr", o_dmem_addr, 32'h200);
    i_dmem_ack = 1'b1;
    tick(); i_dmem_ack = 1'b0;
    chk("sh_valid", 32'(o_valid), 32'd1);
    chk("sh_wren", 32'(o_wr_en), 32'd0);
    chk("sh_err", 32'(o_err), 32'd0);

    // SB 0x301
    drive(7'b0100011, 3'b000, 32'h301, 32'h0000_0055, 5'd0, 1'b0, 2'b00);
    tick(); i_valid = 1'b0;
    chk("sb_wstrb", 32'(o_dmem_wstrb), 32'h2);
    chk("sb_wdata", o_dmem_wdata, 32'h5555_5555);
    i_dmem_ack = 1'b1;
    tick(); i_dmem_ack = 1'b0;
    chk("sb_valid", 32'(o_valid), 32'd1);

    // LW 0x101 misaligned
    drive(7'b0000011, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1, 2'b01);
    tick(); i_valid = 1'b0;
    chk("mis_req", 32'(o_dmem_req), 32'd0);
    chk("mis_valid", 32'(o_valid), 32'd1);
    chk("mis_err", 32'(o_err), 32'd1);
    chk("mis_wren", 32'(o_wr_en), 32'd0);

    // LW timeout with a queued ADD behind it
    drive(7'b0000011, 3'b010, 32'h400, 32'h0, 5'd6, 1'b1, 2'b01);
    tick();
    drive(7'b0110011, 3'b000, 32'h77, 32'h0, 5'd9, 1'b1, 2'b00);
    n = 0;
    for (int i = 0; i < 10 && o_dmem_req; i++) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd4);
    chk("to_valid", 32'(o_valid), 32'd1);
    chk("to_err", 32'(o_err), 32'd2);
    chk("to_wren", 32'(o_wr_en), 32'd0);
    tick(); i_valid = 1'b0;
    chk("to_add_valid", 32'(o_valid), 32'd1);
    chk("to_add_wb", o_wb_data, 32'h77);
    chk("to_add_rd", 32'(o_rd), 32'd9);
    chk("to_add_err", 32'(o_err), 32'd0);

    // Reset during ACCESS, late ack
    drive(7'b0000011, 3'b010, 32'h500, 32'h0, 5'd2, 1'b1, 2'b01);
    tick(); i_valid = 1'b0;
    chk("ra_req", 32'(o_dmem_req), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("ra_req_drop", 32'(o_dmem_req), 32'd0);
    chk("ra_valid", 32'(o_valid), 32'd0);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
    tick(); i_dmem_ack = 1'b0;
    chk("ra_late_ack_valid", 32'(o_valid), 32'd0);
    chk("ra_stall", 32'(o_stall), 32'd0);
    chk("ra_req_idle", 32'(o_dmem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum cycles o_dmem_req waits for i_dmem_ack before a bus error (range 1..255).
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_valid  in  1  EX presents an instruction this cycle.
REQ-005 i_result  in  32  ALU result; byte address for loads/stores.
REQ-006 i_data_store  in  32  rs2 data for stores.
REQ-007 i_pc  in  32  instruction PC.
REQ-008 i_func3  in  3  width/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
REQ-009 i_opcode  in  7  LOAD 0000011, STORE 0100011, others non-memory.
REQ-010 i_rd  in  5  destination register.
REQ-011 i_wr_en  in  1  register-file write request.
REQ-012 i_resultsrc  in  2  writeback select: 00 ALU, 01 load data, 10 PC+4.
REQ-013 o_stall  out  1  EX must hold its outputs and i_valid this cycle.
REQ-014 o_dmem_req  out  1  data-memory request.
REQ-015 o_dmem_we  out  1  request is a store.
REQ-016 o_dmem_addr  out  32  word-aligned address (bits 1:0 = 0).
REQ-017 o_dmem_wdata  out  32  store data, lane-replicated.
REQ-018 o_dmem_wstrb  out  4  byte write strobes, 0 for loads.
REQ-019 i_dmem_ack  in  1  request completes this cycle; rdata valid with it.
REQ-020 i_dmem_rdata  in  32  load word.
REQ-021 o_valid  out  1  one-cycle pulse per retired instruction to WB.
REQ-022 o_wb_data / o_rd / o_wr_en  out  32/5/1  writeback data, register, enable.
REQ-023 o_err  out  2  00 none, 01 misaligned, 10 bus timeout; valid with o_valid.

Function
REQ-024 Instruction is accepted on an edge where i_valid=1 and o_stall=0; o_stall = (state==ACCESS), registered.
REQ-025 FSM states IDLE, ACCESS; IDLE->ACCESS on accepting an aligned LOAD/STORE; ACCESS->IDLE on ack or timeout.
REQ-026 Non-memory op accepted at edge N: o_valid=1 at N+1, o_wb_data per i_resultsrc (PC+4 = i_pc+4, mod 2^32), o_err=00.
REQ-027 Misaligned (half addr[0]=1, word addr[1:0]!=0): no request, o_valid at N+1, o_wr_en=0, o_err=01.
REQ-028 Aligned memory op accepted at edge N: o_dmem_req=1 from N+1, address/data/strobes/we stable until ack.
REQ-029 Ack sampled at edge M: o_dmem_req=0 and o_valid=1 at M+1; ack in the same cycle req first rises is legal.
REQ-030 Load data: byte/half selected by addr[1:0]/addr[1], sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-031 Stores: SB wstrb=0001<<addr[1:0], byte x4; SH wstrb=0011<<(2*addr[1]), half x2; SW 1111; store o_wr_en=0.
REQ-032 8-bit wait counter clears on entry to ACCESS, increments each cycle without ack; at TIMEOUT_CYCLES drops req, o_valid with o_err=10, o_wr_en=0.
REQ-033 o_wr_en = i_wr_en registered, forced 0 on any error; o_valid is 0 in every other cycle.
REQ-034 i_dmem_ack while IDLE is ignored.

Reset
REQ-035 rst=1 at an edge: state IDLE, counter 0, all outputs 0 next cycle, including mid-ACCESS (request abandoned, no o_valid, late ack ignored).

Structure
REQ-036 Opcodes, func3 codes, resultsrc codes, state encoding and o_err codes live in the shared parameters header.
REQ-037 One sub-module, load_store_align: combinational lane steering (wstrb, wdata, load extract, misalign flag).

Verification
REQ-038 ADD, i_result=0x1234, resultsrc=00, rd=5 -> next cycle o_valid=1, o_wb_data=0x1234, o_rd=5, o_stall never 1.
REQ-039 LB addr 0x103, ack after 3 cycles, rdata=0x80FF_FF00 -> o_dmem_addr=0x100, o_wb_data=0xFFFF_FF80, o_stall high 4 cycles.
REQ-040 SH addr 0x202, data 0xABCD_1234, immediate ack -> wstrb=1100, wdata=0x1234_1234, we=1, o_wr_en=0.
REQ-041 LW addr 0x101 -> no o_dmem_req, o_valid next cycle, o_err=01, o_wr_en=0.
REQ-042 LW with TIMEOUT_CYCLES=4, ack never arrives -> req drops after 4 cycles, o_err=10; next queued ADD then retires.
REQ-043 rst during ACCESS, ack one cycle later -> req 0, o_valid stays 0, state IDLE.
